// File: rtl/mod5_bit_serializer_if.sv
// Word-in / bit-out handshake bundle between an upstream word source, the
// serializer and the downstream mod-5 detector.
interface mod5_bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_bit;
    logic             out_valid;
    logic             out_ready;
    logic             frame_first;
    logic             frame_last;
    logic [2:0]       exp_remainder;
    logic             exp_valid;

    // Upstream word source / downstream sink side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_bit, out_valid, frame_first, frame_last,
               exp_remainder, exp_valid
    );

    // Serializer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_bit, out_valid, frame_first, frame_last,
               exp_remainder, exp_valid
    );
endinterface

// File: rtl/mod5_bit_serializer.sv
// MSB-first bit serializer with frame markers; tracks the word's mod-5
// remainder bit by bit so the detector downstream can be checked against it.
module mod5_bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    mod5_bit_serializer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rem_q, rem_d;
    logic [2:0]       exp_rem_q, exp_rem_d;
    logic             exp_valid_q, exp_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    logic [3:0]       step;
    logic [2:0]       rem_next;

    // One step of r' = (2r + b) mod 5; 2r + b is just {r, b}, at most 9.
    always_comb begin
        step     = {rem_q, shreg_q[WIDTH-1]};
        rem_next = (step >= 4'd5) ? 3'(step - 4'd5) : step[2:0];
    end

    // Next-state and next-output logic; outputs are derived from the next
    // state so that the registered copies line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        exp_rem_d = exp_rem_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.in_valid) begin
                    shreg_d = bus.in_data;
                    cnt_d   = '0;
                    rem_d   = 3'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.out_ready) begin
                    rem_d   = rem_next;
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d != SHIFT);
        out_valid_d = (state_d == SHIFT);
        out_bit_d   = (state_d == SHIFT) && shreg_d[WIDTH-1];
        first_d     = (state_d == SHIFT) && (cnt_d == '0);
        last_d      = (state_d == SHIFT) && (cnt_d == CNT_W'(WIDTH - 1));
        exp_valid_d = (state_d == DONE);
        if (state_d == DONE) begin
            exp_rem_d = rem_d;
        end
    end

    // State and output registers; synchronous reset drops any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            rem_q       <= 3'd0;
            exp_rem_q   <= 3'd0;
            exp_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            exp_rem_q   <= exp_rem_d;
            exp_valid_q <= exp_valid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_bit       = out_bit_q;
    assign bus.frame_first   = first_q;
    assign bus.frame_last    = last_q;
    assign bus.exp_valid     = exp_valid_q;
    assign bus.exp_remainder = exp_rem_q;
endmodule
